effect_param_controller: RTL

EFFECT_PARAM_CONTROLLER -- requirements
Module: effect_param_controller

---
 rtl/effect_ctrl_pkg.sv | 15 +
 rtl/key_repeat.sv | 109 ++++++++++
 rtl/effect_param_controller.sv | 124 ++++++++++++
 3 files changed

// File: rtl/effect_ctrl_pkg.sv
// Shared types and default timing constants for the effect parameter controller.
package effect_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPressed,
        StRepeat,
        StLocked
    } key_state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYC     = 500000;
    localparam int unsigned DEFAULT_REPEAT_DELAY_CYC = 25000000;
    localparam int unsigned DEFAULT_REPEAT_RATE_CYC  = 5000000;

endpackage

// File: rtl/key_repeat.sv
// One push-button channel: synchroniser, debouncer, press detect and auto-repeat.
module key_repeat
    import effect_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC     = DEFAULT_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY_CYC = DEFAULT_REPEAT_DELAY_CYC,
    parameter int unsigned REPEAT_RATE_CYC  = DEFAULT_REPEAT_RATE_CYC
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic key_n,
    input  logic cancel,
    output logic key_event
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                      REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic            sync1_q, sync2_q;
    logic            db_q, db_prev_q;
    logic            armed_q;
    logic [DB_W-1:0] db_cnt_q;
    key_state_e      state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic            press, fire;

    // Synchroniser resets to "pressed" so a key held through reset never arms
    // until a genuine release has been seen.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b1;
            db_prev_q <= 1'b1;
            db_cnt_q  <= '0;
            armed_q   <= 1'b0;
            state_q   <= StIdle;
            rpt_cnt_q <= '0;
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            if (sync2_q) begin
                armed_q <= 1'b1;
            end
            if (sync2_q == db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
                db_q     <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    assign press = db_prev_q & ~db_q & armed_q;

    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        fire      = 1'b0;
        if (db_q) begin
            state_d   = StIdle;
            rpt_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (press) begin
                        state_d   = StPressed;
                        rpt_cnt_d = '0;
                    end
                end
                StPressed: begin
                    if (cancel) begin
                        state_d = StLocked;
                    end else if (rpt_cnt_q == RPT_W'(REPEAT_DELAY_CYC - 1)) begin
                        fire      = 1'b1;
                        state_d   = StRepeat;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
                StRepeat: begin
                    if (cancel) begin
                        state_d = StLocked;
                    end else if (rpt_cnt_q == RPT_W'(REPEAT_RATE_CYC - 1)) begin
                        fire      = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
                StLocked: begin
                    state_d = StLocked;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign key_event = press | fire;

endmodule

// File: rtl/effect_param_controller.sv
// Up/down button control of a bank of saturating effect parameters selected by SW[3:0].
module effect_param_controller
    import effect_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PARAMS       = 4,
    parameter int unsigned VAL_W            = 8,
    parameter int unsigned SEL_BASE         = 4,
    parameter logic [NUM_PARAMS*VAL_W-1:0] PARAM_INIT = {NUM_PARAMS{VAL_W'(128)}},
    parameter logic [NUM_PARAMS*VAL_W-1:0] PARAM_MIN  = {NUM_PARAMS{VAL_W'(0)}},
    parameter logic [NUM_PARAMS*VAL_W-1:0] PARAM_MAX  = {NUM_PARAMS{VAL_W'(255)}},
    parameter logic [NUM_PARAMS*VAL_W-1:0] PARAM_STEP = {NUM_PARAMS{VAL_W'(1)}},
    parameter int unsigned DEBOUNCE_CYC     = DEFAULT_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY_CYC = DEFAULT_REPEAT_DELAY_CYC,
    parameter int unsigned REPEAT_RATE_CYC  = DEFAULT_REPEAT_RATE_CYC
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        key_up,
    input  logic                        key_down,
    input  logic [9:0]                  SW,
    output logic [NUM_PARAMS*VAL_W-1:0] param_values,
    output logic                        disabled,
    output logic [NUM_PARAMS-1:0]       value_changed
);

    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_check
        if ((PARAM_MIN[g*VAL_W +: VAL_W] > PARAM_INIT[g*VAL_W +: VAL_W]) ||
            (PARAM_INIT[g*VAL_W +: VAL_W] > PARAM_MAX[g*VAL_W +: VAL_W]) ||
            (PARAM_STEP[g*VAL_W +: VAL_W] == '0)) begin : g_illegal
            $error("effect_param_controller: illegal MIN/INIT/MAX/STEP for parameter %0d", g);
        end
    end

    logic [NUM_PARAMS*VAL_W-1:0] vals_q, vals_d;
    logic [NUM_PARAMS-1:0]       chg_q, chg_d;
    logic                        dis_q;
    logic [3:0]                  sel_q;
    logic                        up_evt, dn_evt, cancel, sel_valid;
    int                          sel_int;
    logic [VAL_W:0]              cur, stp, lim, res;
    logic                        unused_sw;

    assign unused_sw = ^{SW[9:7], SW[5:4]};
    assign sel_int   = int'(SW[3:0]) - int'(SEL_BASE);
    assign sel_valid = (sel_int >= 0) && (sel_int < int'(NUM_PARAMS));
    // Any selection change, valid or not, locks out repeats of a held key.
    assign cancel    = (SW[3:0] != sel_q);

    key_repeat #(
        .DEBOUNCE_CYC    (DEBOUNCE_CYC),
        .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
        .REPEAT_RATE_CYC (REPEAT_RATE_CYC)
    ) u_key_up (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .key_n    (key_up),
        .cancel   (cancel),
        .key_event(up_evt)
    );

    key_repeat #(
        .DEBOUNCE_CYC    (DEBOUNCE_CYC),
        .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
        .REPEAT_RATE_CYC (REPEAT_RATE_CYC)
    ) u_key_down (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .key_n    (key_down),
        .cancel   (cancel),
        .key_event(dn_evt)
    );

    // Arithmetic is one bit wider than a value so neither direction can wrap.
    always_comb begin
        vals_d = vals_q;
        chg_d  = '0;
        cur    = '0;
        stp    = '0;
        lim    = '0;
        res    = '0;
        if (sel_valid && (up_evt ^ dn_evt)) begin
            for (int i = 0; i < int'(NUM_PARAMS); i++) begin
                if (i == sel_int) begin
                    cur = {1'b0, vals_q[i*VAL_W +: VAL_W]};
                    stp = {1'b0, PARAM_STEP[i*VAL_W +: VAL_W]};
                    if (up_evt) begin
                        lim = {1'b0, PARAM_MAX[i*VAL_W +: VAL_W]};
                        res = cur + stp;
                        if (res > lim) begin
                            res = lim;
                        end
                    end else begin
                        lim = {1'b0, PARAM_MIN[i*VAL_W +: VAL_W]};
                        res = cur - stp;
                        if (res[VAL_W] || (res < lim)) begin
                            res = lim;
                        end
                    end
                    vals_d[i*VAL_W +: VAL_W] = res[VAL_W-1:0];
                    chg_d[i]                 = (res != cur);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            vals_q <= PARAM_INIT;
            chg_q  <= '0;
            dis_q  <= 1'b1;
            sel_q  <= '0;
        end else begin
            vals_q <= vals_d;
            chg_q  <= chg_d;
            dis_q  <= ~SW[6];
            sel_q  <= SW[3:0];
        end
    end

    assign param_values  = vals_q;
    assign value_changed = chg_q;
    assign disabled      = dis_q;

endmodule
